// File: rtl/gfx_mem_arbiter_if.sv
// Requester-side and memory-side Avalon-MM signals of the gfx framebuffer arbiter.
// slave = arbiter view, master = surrounding requesters and memory.
interface gfx_mem_arbiter_if;
    logic        scan_read;
    logic [25:0] scan_address;
    logic        scan_waitrequest;
    logic        scan_readdatavalid;
    logic        frag_read;
    logic        frag_write;
    logic [25:0] frag_address;
    logic [15:0] frag_writedata;
    logic        frag_waitrequest;
    logic        frag_readdatavalid;
    logic        clear_write;
    logic [25:0] clear_address;
    logic [15:0] clear_writedata;
    logic        clear_waitrequest;
    logic [15:0] readdata;
    logic [25:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [15:0] mem_readdata;
    logic        rsp_error;

    modport slave (
        input  scan_read, scan_address,
        input  frag_read, frag_write, frag_address, frag_writedata,
        input  clear_write, clear_address, clear_writedata,
        input  mem_waitrequest, mem_readdatavalid, mem_readdata,
        output scan_waitrequest, scan_readdatavalid,
        output frag_waitrequest, frag_readdatavalid,
        output clear_waitrequest, readdata,
        output mem_address, mem_read, mem_write, mem_writedata, rsp_error
    );

    modport master (
        output scan_read, scan_address,
        output frag_read, frag_write, frag_address, frag_writedata,
        output clear_write, clear_address, clear_writedata,
        output mem_waitrequest, mem_readdatavalid, mem_readdata,
        input  scan_waitrequest, scan_readdatavalid,
        input  frag_waitrequest, frag_readdatavalid,
        input  clear_waitrequest, readdata,
        input  mem_address, mem_read, mem_write, mem_writedata, rsp_error
    );
endinterface

// File: rtl/gfx_mem_arbiter.sv
// Shares one Avalon-MM framebuffer port among scan/frag/clear; zero-latency grant, read tags steer readdatavalid.
// Grant locks while mem_waitrequest stalls; define GFX_MEM_ARB_STARVE_GUARD_EN for frag/clear starvation override.
module gfx_mem_arbiter #(
    parameter int unsigned MAX_PENDING  = 8,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    gfx_mem_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(MAX_PENDING);

    if (MAX_PENDING < 2 || (MAX_PENDING & (MAX_PENDING - 1)) != 0) begin : g_bad_depth
        $error("gfx_mem_arbiter: MAX_PENDING must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("gfx_mem_arbiter: STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [1:0] {SRC_NONE, SRC_SCAN, SRC_FRAG, SRC_CLEAR} src_e;

    logic          tag_mem_q [MAX_PENDING];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          fifo_full, fifo_empty, push, pop, head_frag;

    logic          lock_q, lock_d;
    src_e          lock_src_q, lock_src_d;
    logic          rr_clear_q, rr_clear_d;
    logic          rsp_error_q, rsp_error_d;
    logic [25:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          scan_elig, frag_elig, clear_elig;
    logic          frag_starved, clear_starved;
    src_e          win;
    logic          win_wr, accept;

    assign fifo_full  = (cnt_q == (PW+1)'(MAX_PENDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_frag  = tag_mem_q[rptr_q];

    // A write from frag takes precedence over a simultaneous frag read.
    assign scan_elig  = bus.scan_read && !fifo_full;
    assign frag_elig  = bus.frag_write || (bus.frag_read && !fifo_full);
    assign clear_elig = bus.clear_write;

`ifdef GFX_MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] frag_wait_q, frag_wait_d, clear_wait_q, clear_wait_d;

    always_comb begin
        frag_wait_d  = frag_wait_q;
        clear_wait_d = clear_wait_q;
        if (accept && win == SRC_FRAG) begin
            frag_wait_d = '0;
        end else if (frag_elig && win != SRC_FRAG && frag_wait_q != LIMIT) begin
            frag_wait_d = frag_wait_q + CW'(1);
        end
        if (accept && win == SRC_CLEAR) begin
            clear_wait_d = '0;
        end else if (clear_elig && win != SRC_CLEAR && clear_wait_q != LIMIT) begin
            clear_wait_d = clear_wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frag_wait_q  <= '0;
            clear_wait_q <= '0;
        end else begin
            frag_wait_q  <= frag_wait_d;
            clear_wait_q <= clear_wait_d;
        end
    end

    assign frag_starved  = (frag_wait_q == LIMIT);
    assign clear_starved = (clear_wait_q == LIMIT);
`else
    assign frag_starved  = 1'b0;
    assign clear_starved = 1'b0;
`endif

    // A stalled grant stays with its port until accepted, ahead of every other rule.
    always_comb begin
        win = SRC_NONE;
        if (!rst) begin
            if (lock_q && lock_src_q == SRC_SCAN && scan_elig)             win = SRC_SCAN;
            else if (lock_q && lock_src_q == SRC_FRAG && frag_elig)        win = SRC_FRAG;
            else if (lock_q && lock_src_q == SRC_CLEAR && clear_elig)      win = SRC_CLEAR;
            else if (frag_starved && frag_elig)                            win = SRC_FRAG;
            else if (clear_starved && clear_elig)                          win = SRC_CLEAR;
            else if (scan_elig)                                            win = SRC_SCAN;
            else if (frag_elig && !(rr_clear_q && clear_elig))             win = SRC_FRAG;
            else if (clear_elig)                                           win = SRC_CLEAR;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        win_wr  = 1'b0;
        case (win)
            SRC_SCAN: addr_d = bus.scan_address;
            SRC_FRAG: begin
                addr_d = bus.frag_address;
                win_wr = bus.frag_write;
                if (bus.frag_write) wdata_d = bus.frag_writedata;
            end
            SRC_CLEAR: begin
                addr_d  = bus.clear_address;
                wdata_d = bus.clear_writedata;
                win_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = (win != SRC_NONE) && !bus.mem_waitrequest;
    assign push   = accept && !win_wr;
    assign pop    = !rst && bus.mem_readdatavalid && !fifo_empty;

    assign bus.mem_address        = addr_d;
    assign bus.mem_writedata      = wdata_d;
    assign bus.mem_read           = (win != SRC_NONE) && !win_wr;
    assign bus.mem_write          = (win != SRC_NONE) && win_wr;
    assign bus.scan_waitrequest   = !(accept && win == SRC_SCAN);
    assign bus.frag_waitrequest   = !(accept && win == SRC_FRAG);
    assign bus.clear_waitrequest  = !(accept && win == SRC_CLEAR);
    assign bus.scan_readdatavalid = pop && !head_frag;
    assign bus.frag_readdatavalid = pop && head_frag;
    assign bus.readdata           = bus.mem_readdata;
    assign bus.rsp_error          = rsp_error_q;

    always_comb begin
        lock_d      = (win != SRC_NONE) && bus.mem_waitrequest;
        lock_src_d  = win;
        rr_clear_d  = rr_clear_q;
        rsp_error_d = rsp_error_q || (bus.mem_readdatavalid && fifo_empty);
        if (accept && win == SRC_FRAG)  rr_clear_d = 1'b1;
        if (accept && win == SRC_CLEAR) rr_clear_d = 1'b0;
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q      <= 1'b0;
            lock_src_q  <= SRC_NONE;
            rr_clear_q  <= 1'b0;
            rsp_error_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_src_q  <= lock_src_d;
            rr_clear_q  <= rr_clear_d;
            rsp_error_q <= rsp_error_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wptr_q] <= (win == SRC_FRAG);
    end
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Directed bench for gfx_mem_arbiter: priority, round-robin, lock, tag FIFO and error paths.
module tb_gfx_mem_arbiter;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    gfx_mem_arbiter_if bus ();

    gfx_mem_arbiter #(.MAX_PENDING(8), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.scan_read         = 1'b0;
        bus.scan_address      = '0;
        bus.frag_read         = 1'b0;
        bus.frag_write        = 1'b0;
        bus.frag_address      = '0;
        bus.frag_writedata    = '0;
        bus.clear_write       = 1'b0;
        bus.clear_address     = '0;
        bus.clear_writedata   = '0;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata      = '0;
    endtask

    initial begin
        // reset with requests present
        rst = 1'b1;
        idle();
        bus.scan_read   = 1'b1;
        bus.clear_write = 1'b1;
        #1;
        chk("rst_scan_wr",  32'(bus.scan_waitrequest), 1);
        chk("rst_frag_wr",  32'(bus.frag_waitrequest), 1);
        chk("rst_clear_wr", 32'(bus.clear_waitrequest), 1);
        chk("rst_mem_read", 32'(bus.mem_read), 0);
        chk("rst_mem_write", 32'(bus.mem_write), 0);
        chk("rst_scan_rdv", 32'(bus.scan_readdatavalid), 0);
        chk("rst_frag_rdv", 32'(bus.frag_readdatavalid), 0);
        cyc();
        cyc();
        idle();
        rst = 1'b0;
        #1;
        chk("rst_rsp_error", 32'(bus.rsp_error), 0);

        // single scan read, response three cycles later
        bus.scan_read    = 1'b1;
        bus.scan_address = 26'h100;
        #1;
        chk("t1_mem_read", 32'(bus.mem_read), 1);
        chk("t1_mem_addr", 32'(bus.mem_address), 32'h100);
        chk("t1_scan_wr",  32'(bus.scan_waitrequest), 0);
        chk("t1_mem_write", 32'(bus.mem_write), 0);
        cyc();
        bus.scan_read = 1'b0;
        #1;
        chk("t1_idle_read", 32'(bus.mem_read), 0);
        chk("t1_hold_addr", 32'(bus.mem_address), 32'h100);
        cyc();
        cyc();
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = 16'hBEEF;
        #1;
        chk("t1_scan_rdv", 32'(bus.scan_readdatavalid), 1);
        chk("t1_frag_rdv", 32'(bus.frag_readdatavalid), 0);
        chk("t1_readdata", 32'(bus.readdata), 32'hBEEF);
        cyc();
        bus.mem_readdatavalid = 1'b0;

        // frag/clear round-robin; frag read ignored while frag writes
        bus.frag_write      = 1'b1;
        bus.frag_read       = 1'b1;
        bus.frag_address    = 26'h10;
        bus.frag_writedata  = 16'hAAAA;
        bus.clear_write     = 1'b1;
        bus.clear_address   = 26'h20;
        bus.clear_writedata = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (i % 2 == 0) begin
                chk("t2_frag_turn_wr",  32'(bus.frag_waitrequest), 0);
                chk("t2_frag_turn_cwr", 32'(bus.clear_waitrequest), 1);
                chk("t2_frag_addr",     32'(bus.mem_address), 32'h10);
                chk("t2_frag_data",     32'(bus.mem_writedata), 32'hAAAA);
                chk("t2_frag_read0",    32'(bus.mem_read), 0);
            end else begin
                chk("t2_clear_turn_wr",  32'(bus.clear_waitrequest), 0);
                chk("t2_clear_turn_fwr", 32'(bus.frag_waitrequest), 1);
                chk("t2_clear_addr",     32'(bus.mem_address), 32'h20);
                chk("t2_clear_data",     32'(bus.mem_writedata), 32'h5555);
            end
            chk("t2_mem_write", 32'(bus.mem_write), 1);
            cyc();
        end
        bus.scan_read    = 1'b1;
        bus.scan_address = 26'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_scan_wins",  32'(bus.scan_waitrequest), 0);
            chk("t2_scan_fwr",   32'(bus.frag_waitrequest), 1);
            chk("t2_scan_cwr",   32'(bus.clear_waitrequest), 1);
            chk("t2_scan_read",  32'(bus.mem_read), 1);
            chk("t2_scan_addr",  32'(bus.mem_address), 32'h200);
            cyc();
        end
        bus.scan_read = 1'b0;
        #1;
        chk("t2_rr_frag_next", 32'(bus.frag_waitrequest), 0);
        chk("t2_rr_clear_wait", 32'(bus.clear_waitrequest), 1);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.mem_readdatavalid = 1'b1;
            bus.mem_readdata      = 16'(i + 16'h70);
            #1;
            chk("t2_drain_scan_rdv", 32'(bus.scan_readdatavalid), 1);
            chk("t2_drain_data", 32'(bus.readdata), 32'(i + 16'h70));
            cyc();
        end
        bus.mem_readdatavalid = 1'b0;

        // stalled clear write keeps the port while scan arrives
        bus.clear_write     = 1'b1;
        bus.clear_address   = 26'h20;
        bus.clear_writedata = 16'h1234;
        bus.mem_waitrequest = 1'b1;
        #1;
        chk("t3_c0_write", 32'(bus.mem_write), 1);
        chk("t3_c0_addr",  32'(bus.mem_address), 32'h20);
        chk("t3_c0_cwr",   32'(bus.clear_waitrequest), 1);
        cyc();
        bus.scan_read    = 1'b1;
        bus.scan_address = 26'h300;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("t3_lock_addr",  32'(bus.mem_address), 32'h20);
            chk("t3_lock_write", 32'(bus.mem_write), 1);
            chk("t3_lock_read",  32'(bus.mem_read), 0);
            chk("t3_lock_swr",   32'(bus.scan_waitrequest), 1);
            chk("t3_lock_cwr",   32'(bus.clear_waitrequest), 1);
            cyc();
        end
        bus.mem_waitrequest = 1'b0;
        #1;
        chk("t3_accept_cwr", 32'(bus.clear_waitrequest), 0);
        chk("t3_accept_addr", 32'(bus.mem_address), 32'h20);
        chk("t3_accept_swr", 32'(bus.scan_waitrequest), 1);
        cyc();
        bus.clear_write = 1'b0;
        #1;
        chk("t3_scan_after_swr",  32'(bus.scan_waitrequest), 0);
        chk("t3_scan_after_read", 32'(bus.mem_read), 1);
        chk("t3_scan_after_addr", 32'(bus.mem_address), 32'h300);
        cyc();
        bus.scan_read         = 1'b0;
        bus.mem_readdatavalid = 1'b1;
        #1;
        chk("t3_drain_rdv", 32'(bus.scan_readdatavalid), 1);
        cyc();
        bus.mem_readdatavalid = 1'b0;

        // tag FIFO full blocks reads, not writes
        bus.scan_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.scan_address = 26'h400 + 26'(i);
            #1;
            chk("t4_fill_swr", 32'(bus.scan_waitrequest), 0);
            cyc();
        end
        bus.scan_address = 26'h500;
        #1;
        chk("t4_full_swr",  32'(bus.scan_waitrequest), 1);
        chk("t4_full_read", 32'(bus.mem_read), 0);
        chk("t4_full_hold", 32'(bus.mem_address), 32'h407);
        bus.clear_write     = 1'b1;
        bus.clear_address   = 26'h50;
        bus.clear_writedata = 16'h0F0F;
        #1;
        chk("t4_clear_cwr",   32'(bus.clear_waitrequest), 0);
        chk("t4_clear_write", 32'(bus.mem_write), 1);
        chk("t4_clear_addr",  32'(bus.mem_address), 32'h50);
        chk("t4_clear_swr",   32'(bus.scan_waitrequest), 1);
        cyc();
        bus.clear_write       = 1'b0;
        bus.mem_readdatavalid = 1'b1;
        #1;
        chk("t4_pop_rdv", 32'(bus.scan_readdatavalid), 1);
        chk("t4_pop_swr", 32'(bus.scan_waitrequest), 1);
        cyc();
        bus.mem_readdatavalid = 1'b0;
        #1;
        chk("t4_resume_swr",  32'(bus.scan_waitrequest), 0);
        chk("t4_resume_read", 32'(bus.mem_read), 1);
        chk("t4_resume_addr", 32'(bus.mem_address), 32'h500);
        cyc();
        bus.scan_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_readdatavalid = 1'b1;
            #1;
            chk("t4_drain_rdv", 32'(bus.scan_readdatavalid), 1);
            cyc();
        end
        bus.mem_readdatavalid = 1'b0;

        // interleaved scan/frag reads return in order
        bus.scan_read    = 1'b1;
        bus.scan_address = 26'h1;
        #1;
        chk("t5_scan1_swr", 32'(bus.scan_waitrequest), 0);
        cyc();
        bus.scan_read    = 1'b0;
        bus.frag_read    = 1'b1;
        bus.frag_address = 26'h2;
        #1;
        chk("t5_frag_fwr",  32'(bus.frag_waitrequest), 0);
        chk("t5_frag_read", 32'(bus.mem_read), 1);
        cyc();
        bus.frag_read    = 1'b0;
        bus.scan_read    = 1'b1;
        bus.scan_address = 26'h3;
        #1;
        chk("t5_scan2_swr", 32'(bus.scan_waitrequest), 0);
        cyc();
        bus.scan_read         = 1'b0;
        bus.mem_readdatavalid = 1'b1;
        bus.mem_readdata      = 16'h1;
        #1;
        chk("t5_r1_scan", 32'(bus.scan_readdatavalid), 1);
        chk("t5_r1_frag", 32'(bus.frag_readdatavalid), 0);
        chk("t5_r1_data", 32'(bus.readdata), 32'h1);
        cyc();
        bus.mem_readdata = 16'h2;
        #1;
        chk("t5_r2_scan", 32'(bus.scan_readdatavalid), 0);
        chk("t5_r2_frag", 32'(bus.frag_readdatavalid), 1);
        chk("t5_r2_data", 32'(bus.readdata), 32'h2);
        cyc();
        bus.mem_readdata = 16'h3;
        #1;
        chk("t5_r3_scan", 32'(bus.scan_readdatavalid), 1);
        chk("t5_r3_frag", 32'(bus.frag_readdatavalid), 0);
        cyc();
        bus.mem_readdata = 16'h4;
        #1;
        chk("t5_extra_scan", 32'(bus.scan_readdatavalid), 0);
        chk("t5_extra_frag", 32'(bus.frag_readdatavalid), 0);
        chk("t5_err_before", 32'(bus.rsp_error), 0);
        cyc();
        bus.mem_readdatavalid = 1'b0;
        #1;
        chk("t5_err_set", 32'(bus.rsp_error), 1);
        cyc();
        #1;
        chk("t5_err_sticky", 32'(bus.rsp_error), 1);

        // reset mid-command drops lock, tags, round-robin and error
        bus.scan_read    = 1'b1;
        bus.scan_address = 26'h6;
        #1;
        chk("t6_pre_scan_swr", 32'(bus.scan_waitrequest), 0);
        cyc();
        bus.scan_read       = 1'b0;
        bus.clear_write     = 1'b1;
        bus.clear_address   = 26'h60;
        bus.mem_waitrequest = 1'b1;
        #1;
        chk("t6_stall_cwr", 32'(bus.clear_waitrequest), 1);
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_rst_write", 32'(bus.mem_write), 0);
        cyc();
        rst                   = 1'b0;
        bus.mem_waitrequest   = 1'b0;
        bus.frag_write        = 1'b1;
        bus.frag_address      = 26'h61;
        bus.mem_readdatavalid = 1'b1;
        #1;
        chk("t6_err_cleared", 32'(bus.rsp_error), 0);
        chk("t6_frag_wins",   32'(bus.frag_waitrequest), 0);
        chk("t6_clear_waits", 32'(bus.clear_waitrequest), 1);
        chk("t6_addr",        32'(bus.mem_address), 32'h61);
        chk("t6_late_scan",   32'(bus.scan_readdatavalid), 0);
        chk("t6_late_frag",   32'(bus.frag_readdatavalid), 0);
        cyc();
        idle();
        #1;
        chk("t6_late_err", 32'(bus.rsp_error), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
